// File: rtl/insdec_pkg.sv
// insdec_pkg: decoded-bundle type and encoding constants for the ID/RF decode stage.
// The register-index width of the bundle defaults to 4;
// the optional perf counters in insdec_stage are enabled by INSDEC_PERF_EN.
package insdec_pkg;
  localparam int DEC_REG_W = 4;
  localparam int ADDR_W = 10;   // jump/TOS address width, fixed by the encoding
  localparam int LO_W   = 20;   // fixed-encoding low field, register indices sit above it
  // class-decode opcode bit positions
  localparam int B2 = 2;
  localparam int B3 = 3;
  localparam int B4 = 4;
  localparam int B5 = 5;

  typedef struct packed {
    logic [1:0]           alusel0;
    logic [1:0]           alusel1;
    logic [2:0]           flags;
    logic                 inc;
    logic                 sh1dir;
    logic                 sh2dir;
    logic [3:0]           sh1;
    logic [3:0]           sh2;
    logic                 isSIMD;
    logic                 isJump;
    logic                 pop;
    logic                 zcmpw;
    logic                 setTOS;
    logic                 isHalted;
    logic                 idf;
    logic [ADDR_W-1:0]    jumpAddr;
    logic [DEC_REG_W-1:0] rs0;
    logic [DEC_REG_W-1:0] rs1;
    logic [DEC_REG_W-1:0] rd;
  } dec_t;
endpackage

// File: rtl/insdec_if.sv
// insdec_if: fetch-side and RF-side valid/ready handshakes of the decode stage.
// slave = the decode stage, master = its environment (fetch + RF read).
interface insdec_if
  import insdec_pkg::*;
#(
  parameter int REG_W = DEC_REG_W
);
  localparam int INS_W = LO_W + 3*REG_W;

  logic             in_valid;
  logic             in_ready;
  logic [INS_W-1:0] ins;
  logic             out_valid;
  logic             out_ready;
  dec_t             out_dec;

  modport slave  (input  in_valid, ins, out_ready,
                  output in_ready, out_valid, out_dec);
  modport master (output in_valid, ins, out_ready,
                  input  in_ready, out_valid, out_dec);
endinterface

// File: rtl/insdec_fields.sv
// insdec_fields: purely combinational instruction word -> decoded field bundle.
module insdec_fields
  import insdec_pkg::*;
#(
  parameter  int REG_W = DEC_REG_W,
  localparam int INS_W = LO_W + 3*REG_W
) (
  input  logic [INS_W-1:0] ins,
  output dec_t             dec
);
  logic b5, b4, b3, b2;
  assign b5 = ins[B5];
  assign b4 = ins[B4];
  assign b3 = ins[B3];
  assign b2 = ins[B2];

  // raw field slicing plus opcode-class decode
  always_comb begin
    dec          = '0;
    dec.alusel0  = ins[1:0];
    dec.alusel1  = ins[3:2];
    dec.flags    = ins[8:6];
    dec.inc      = ins[9];
    dec.sh1      = ins[13:10];
    dec.sh1dir   = ins[14];
    dec.sh2      = ins[18:15];
    dec.sh2dir   = ins[19];
    dec.jumpAddr = ins[19:10];
    dec.isSIMD   = ~b5 & ~b4;
    dec.isJump   =  b5 & ~b3;
    dec.pop      =  b5 &  b3;
    dec.zcmpw    =  b4 & ~b3 & ~b2;
    dec.setTOS   = ~b5 &  b3 &  b2;
    dec.isHalted =  b5 &  b4 &  b3;
    dec.idf      =  b4 &  b3 & ~b2;
    dec.rs0      = ins[LO_W           +: REG_W];
    dec.rs1      = ins[LO_W + REG_W   +: REG_W];
    dec.rd       = ins[LO_W + 2*REG_W +: REG_W];
  end
endmodule

// File: rtl/insdec_stage.sv
// insdec_stage: registered instruction decode with a 2-entry skid buffer, thread halt
// state and TOS register. Define INSDEC_PERF_EN to add perf_dec/perf_stall counters.
module insdec_stage
  import insdec_pkg::*;
#(
  parameter int REG_W  = DEC_REG_W,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  insdec_if.slave           bus,
  input  logic              flush,
  input  logic              resume,
  output logic              halted,
  output logic [ADDR_W-1:0] tos
`ifdef INSDEC_PERF_EN
  ,
  output logic [31:0]       perf_dec,
  output logic [31:0]       perf_stall
`endif
);
  if (ADDR_W != insdec_pkg::ADDR_W) begin : g_addr_chk
    $error("insdec_stage: ADDR_W must be 10");
  end
  if (REG_W != DEC_REG_W) begin : g_reg_chk
    $error("insdec_stage: REG_W must match the dec_t register-index width");
  end

  dec_t dec, out_q, skid_q;
  logic out_v, skid_v, acc, acc_ok;

  insdec_fields #(.REG_W(REG_W)) u_fields (.ins(bus.ins), .dec(dec));

  // in_ready depends only on registered state, never on out_ready
  assign bus.in_ready  = ~skid_v & ~halted;
  assign bus.out_valid = out_v;
  assign bus.out_dec   = out_q;
  assign acc           = bus.in_valid & bus.in_ready;
  assign acc_ok        = acc & ~flush;   // an accept under flush is dropped entirely

  // output register + skid: fill output when it is empty or draining, else park in skid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
      out_q  <= '0;
      skid_q <= '0;
    end else if (flush) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (!out_v || bus.out_ready) begin
      if (skid_v) begin
        out_q  <= skid_q;
        out_v  <= 1'b1;
        skid_v <= 1'b0;
      end else if (acc) begin
        out_q <= dec;
        out_v <= 1'b1;
      end else begin
        out_v <= 1'b0;
      end
    end else if (acc) begin
      skid_q <= dec;
      skid_v <= 1'b1;
    end
  end

  // halt state: a halt accept wins over a same-cycle resume
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       halted <= 1'b0;
    else if (acc_ok && dec.isHalted)  halted <= 1'b1;
    else if (resume)                  halted <= 1'b0;
  end

  // TOS load on setTOS accept; flush does not revert it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    tos <= '0;
    else if (acc_ok && dec.setTOS) tos <= dec.jumpAddr;
  end

`ifdef INSDEC_PERF_EN
  // free-running wrap-around counters: output handshakes and input stall cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_dec   <= '0;
      perf_stall <= '0;
    end else begin
      perf_dec   <= perf_dec   + {31'd0, out_v & bus.out_ready};
      perf_stall <= perf_stall + {31'd0, bus.in_valid & ~bus.in_ready};
    end
  end
`endif
endmodule

// File: tb/tb_insdec_stage.sv
// tb_insdec_stage: directed vectors, expected bundles queued on accept, checked by a monitor.
module tb_insdec_stage;
  import insdec_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic resume = 1'b0;
  logic halted;
  logic [9:0] tos;
`ifdef INSDEC_PERF_EN
  logic [31:0] perf_dec, perf_stall;
`endif

  insdec_if #(.REG_W(4)) bus ();

  insdec_stage #(.REG_W(4), .ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .flush(flush), .resume(resume),
    .halted(halted), .tos(tos)
`ifdef INSDEC_PERF_EN
    , .perf_dec(perf_dec), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] cls;  logic [1:0] a0; logic [2:0] fl; logic inc; logic [9:0] hi;
    logic [3:0] r0;   logic [3:0] r1; logic [3:0] rd;
    logic [6:0] cb;   // {isSIMD,isJump,pop,zcmpw,setTOS,isHalted,idf}, hand-derived
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  dec_t sb[$];
  vec_t vt[10];
  vec_t v_halt2, v_tos, v_tos_fl;

  function automatic vec_t mkv(logic [3:0] cls, logic [1:0] a0, logic [2:0] fl, logic inc,
                               logic [9:0] hi, logic [3:0] r0, logic [3:0] r1, logic [3:0] rd,
                               logic [6:0] cb);
    vec_t v;
    v.cls = cls; v.a0 = a0; v.fl = fl; v.inc = inc; v.hi = hi;
    v.r0 = r0; v.r1 = r1; v.rd = rd; v.cb = cb;
    return v;
  endfunction

  function automatic logic [31:0] mk_ins(vec_t v);
    return {v.rd, v.r1, v.r0, v.hi, v.inc, v.fl, v.cls, v.a0};
  endfunction

  function automatic dec_t mk_exp(vec_t v);
    dec_t e;
    e = '0;
    e.alusel0 = v.a0;      e.alusel1 = v.cls[1:0];
    e.flags   = v.fl;      e.inc     = v.inc;
    e.sh1     = v.hi[3:0]; e.sh1dir  = v.hi[4];
    e.sh2     = v.hi[8:5]; e.sh2dir  = v.hi[9];
    e.jumpAddr = v.hi;
    {e.isSIMD, e.isJump, e.pop, e.zcmpw, e.setTOS, e.isHalted, e.idf} = v.cb;
    e.rs0 = v.r0; e.rs1 = v.r1; e.rd = v.rd;
    return e;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // present one instruction, wait (bounded) for in_ready, queue its expected bundle on accept
  task automatic send(vec_t v);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.ins      = mk_ins(v);
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    sb.push_back(mk_exp(v));
    bus.in_valid = 1'b0;
  endtask

  // monitor: compare every output handshake against the queue; check hold stability
  dec_t held_dec;
  logic held = 1'b0;
  always @(negedge clk) begin
    if (held && bus.out_valid) chk("hold_stable", 64'(bus.out_dec), 64'(held_dec));
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) chk("unexpected_output", 64'(bus.out_dec), 64'd0);
      else chk("out_dec", 64'(bus.out_dec), 64'(sb.pop_front()));
    end
    held     = bus.out_valid & ~bus.out_ready;
    held_dec = bus.out_dec;
  end

  initial begin
    bus.in_valid = 1'b0; bus.ins = '0; bus.out_ready = 1'b1;
    //                cls     a0    fl      inc   hi       r0  r1  rd   cb
    vt[0] = mkv(4'b0000, 2'd1, 3'b101, 1'b1, 10'h2A5, 3,  5,  7,  7'b1000000);
    vt[1] = mkv(4'b0011, 2'd2, 3'b010, 1'b0, 10'h0F0, 1,  2,  3,  7'b1000100);
    vt[2] = mkv(4'b0100, 2'd3, 3'b111, 1'b1, 10'h3FF, 15, 0,  9,  7'b0001000);
    vt[3] = mkv(4'b0110, 2'd0, 3'b000, 1'b0, 10'h001, 4,  4,  4,  7'b0000001);
    vt[4] = mkv(4'b1000, 2'd1, 3'b100, 1'b1, 10'h200, 8,  9,  10, 7'b0100000);
    vt[5] = mkv(4'b1010, 2'd2, 3'b011, 1'b0, 10'h155, 11, 12, 13, 7'b0010000);
    vt[6] = mkv(4'b1001, 2'd3, 3'b001, 1'b1, 10'h0AA, 14, 15, 1,  7'b0100000);
    vt[7] = mkv(4'b0111, 2'd0, 3'b110, 1'b0, 10'h123, 2,  6,  10, 7'b0000100);
    vt[8] = mkv(4'b0001, 2'd1, 3'b000, 1'b0, 10'h000, 0,  1,  2,  7'b1000000);
    vt[9] = mkv(4'b1111, 2'd3, 3'b111, 1'b1, 10'h3C3, 5,  6,  7,  7'b0010010);
    v_halt2  = mkv(4'b1110, 2'd0, 3'b001, 1'b0, 10'h011, 1, 1, 1, 7'b0010011);
    v_tos    = mkv(4'b0011, 2'd0, 3'b000, 1'b0, 10'h155, 0, 0, 0, 7'b1000100);
    v_tos_fl = mkv(4'b0011, 2'd1, 3'b000, 1'b0, 10'h0AB, 0, 0, 0, 7'b1000100);

    // reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_halted",    64'(halted),        64'd0);
    chk("rst_tos",       64'(tos),           64'd0);
    chk("rst_out_dec",   64'(bus.out_dec),   64'd0);

    // first instruction: one-cycle latency, SIMD with rs0/rs1/rd = 3/5/7
    @(posedge clk); #1;
    send(vt[0]);
    @(negedge clk);
    chk("lat_valid", 64'(bus.out_valid),      64'd1);
    chk("lat_simd",  64'(bus.out_dec.isSIMD), 64'd1);
    chk("lat_rs",    64'({bus.out_dec.rs0, bus.out_dec.rs1, bus.out_dec.rd}), 64'h357);

    // back-to-back stream ending in a halt, then 3 cycles offered while halted
    @(posedge clk); #1;
    for (int i = 1; i < 10; i++) send(vt[i]);
    bus.in_valid = 1'b1; bus.ins = mk_ins(vt[0]);
    repeat (3) @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("halt_set",      64'(halted),      64'd1);
    chk("halt_in_ready", 64'(bus.in_ready), 64'd0);
    chk("tos_stream",    64'(tos),         64'h123);
    chk("stream_empty",  64'(sb.size()),   64'd0);
`ifdef INSDEC_PERF_EN
    chk("perf_dec",   64'(perf_dec),   64'd10);
    chk("perf_stall", 64'(perf_stall), 64'd3);
`endif

    // resume pulse
    @(posedge clk); #1 resume = 1'b1;
    @(posedge clk); #1 resume = 1'b0;
    @(negedge clk);
    chk("resume_in_ready", 64'(bus.in_ready), 64'd1);
    chk("resume_halted",   64'(halted),       64'd0);

    // resume coincident with a halt accept: halt wins
    @(posedge clk); #1 resume = 1'b1;
    send(v_halt2);
    resume = 1'b0;
    @(negedge clk);
    chk("halt_vs_resume", 64'(halted), 64'd1);
    @(posedge clk); #1 resume = 1'b1;
    @(posedge clk); #1 resume = 1'b0;

    // setTOS
    send(v_tos);
    @(negedge clk);
    chk("tos_load", 64'(tos), 64'h155);

    // out_ready low for 2 cycles under continuous input: skid fills, in_ready drops
    @(posedge clk); #1;
    fork
      begin
        for (int i = 2; i < 6; i++) send(vt[i]);
      end
      begin
        @(posedge clk); #1 bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("skid_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1 bus.out_ready = 1'b1;
      end
    join
    begin
      int n = 0;
      while (sb.size() != 0 && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    chk("stream_drained", 64'(sb.size()), 64'd0);

    // flush with output and skid both full
    @(posedge clk); #1 bus.out_ready = 1'b0;
    send(vt[2]);
    send(vt[3]);
    @(negedge clk);
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_in_ready",  64'(bus.in_ready),  64'd1);

    // flush with a same-cycle halt accept, then with a same-cycle setTOS accept
    send(vt[4]);
    flush = 1'b1; bus.in_valid = 1'b1; bus.ins = mk_ins(vt[9]);
    @(posedge clk); #1 flush = 1'b0; bus.in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("flush_halt",  64'(halted),        64'd0);
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    flush = 1'b1; bus.in_valid = 1'b1; bus.ins = mk_ins(v_tos_fl);
    @(posedge clk); #1 flush = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_tos", 64'(tos), 64'h155);

    // asynchronous reset mid-stream
    @(posedge clk); #1;
    send(vt[2]);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_tos",       64'(tos),           64'd0);
    sb.delete();
    @(posedge clk); #1 rst_n = 1'b1; bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
